control_sequencer: RTL and testbench

Hardwired control unit that drives the existing single-bus datapath through instruction fetch and execution of register-register and unary ALU instructions, including the two-result mul/div path. It replaces testbench-driven control strobes (PC_out, MAR_in, Read, MDR_in, IR_in, Y_in, Z_in, Zlow_out and so on) with a cycle-accurate state machine. It decodes IR fields and produces one-hot register in/out selects. A memory-ready handshake stretches fetch when memory is slow.

---
 rtl/control_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired control unit for the single-bus datapath. Sequences instruction
//   fetch (with a memory-ready stretch) and execution of binary, wide (mul/div),
//   unary and control instructions. All strobes are Moore outputs decoded from
//   the current state, plus IR fields in the execute states.
//
// Ports
//   clk, clr            clock, asynchronous active-high reset
//   ir[31:0]            IR contents: op[31:27] Ra[26:23] Rb[22:19] Rc[18:15]
//   mem_ready           memory read done (sampled in FETCH1)
//   stop                pause request, taken only at an instruction boundary
//   PC_out..IR_in       fetch strobes
//   Y_in..LO_in         execute strobes
//   Rin, Rout           one-hot register load / bus-drive selects
//   alu_instruction     ALU opcode during the ALU cycle, else 0
//   run                 high while sequencing
//   illegal             pulse on undefined opcode or out-of-range register field
module control_sequencer #(
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  input  logic             stop,
  output logic             PC_out,
  output logic             PC_in,
  output logic             IncPC,
  output logic             MAR_in,
  output logic             Read,
  output logic             MDR_in,
  output logic             MDR_out,
  output logic             IR_in,
  output logic             Y_in,
  output logic             Z_in,
  output logic             Zlow_out,
  output logic             Zhigh_out,
  output logic             HI_in,
  output logic             LO_in,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic [4:0]       alu_instruction,
  output logic             run,
  output logic             illegal
);

  localparam logic [3:0] S_RESET   = 4'd0;
  localparam logic [3:0] S_FETCH0  = 4'd1;
  localparam logic [3:0] S_FETCH1  = 4'd2;
  localparam logic [3:0] S_FETCH2  = 4'd3;
  localparam logic [3:0] S_EX1     = 4'd4;
  localparam logic [3:0] S_EX2     = 4'd5;
  localparam logic [3:0] S_EX3     = 4'd6;
  localparam logic [3:0] S_EX4     = 4'd7;
  localparam logic [3:0] S_STOPPED = 4'd8;
  localparam logic [3:0] S_HALTED  = 4'd9;

  logic [3:0] state, state_nx;
  logic       f1_first;   // high only in the first FETCH1 cycle

  // IR fields
  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  assign op = ir[31:27];
  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];

  logic unused_ir;
  assign unused_ir = ^ir[14:0];

  // Opcode classes
  logic is_bin, is_wide, is_un, is_nop, is_halt, is_ill;
  always_comb begin
    is_bin  = 1'b0;
    is_wide = 1'b0;
    is_un   = 1'b0;
    is_nop  = 1'b0;
    is_halt = 1'b0;
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: is_bin  = 1'b1;
      5'b01111, 5'b10000:                     is_wide = 1'b1;
      5'b10001, 5'b10010:                     is_un   = 1'b1;
      5'b11010:                               is_nop  = 1'b1;
      5'b11011:                               is_halt = 1'b1;
      default: ;
    endcase
    is_ill = ~(is_bin | is_wide | is_un | is_nop | is_halt);
  end

  // Register fields beyond NREGS select nothing and flag illegal
  logic ra_bad, rb_bad, rc_bad;
  assign ra_bad = int'(ra) >= NREGS;
  assign rb_bad = int'(rb) >= NREGS;
  assign rc_bad = int'(rc) >= NREGS;

  function automatic logic [NREGS-1:0] sel(input logic [3:0] f, input logic bad);
    sel = bad ? '0 : (NREGS'(1) << f);
  endfunction

  // After the final execute state: pause if requested, else fetch next
  logic [3:0] s_boundary;
  assign s_boundary = stop ? S_STOPPED : S_FETCH0;

  always_comb begin
    state_nx = state;
    case (state)
      S_RESET:   state_nx = S_FETCH0;
      S_FETCH0:  state_nx = S_FETCH1;
      S_FETCH1:  state_nx = mem_ready ? S_FETCH2 : S_FETCH1;
      S_FETCH2:  state_nx = S_EX1;
      S_EX1:     if (is_halt)                        state_nx = S_HALTED;
                 else if (is_bin | is_wide | is_un)  state_nx = S_EX2;
                 else                                state_nx = s_boundary;
      S_EX2:     state_nx = is_un ? s_boundary : S_EX3;
      S_EX3:     state_nx = is_wide ? S_EX4 : s_boundary;
      S_EX4:     state_nx = s_boundary;
      S_STOPPED: state_nx = stop ? S_STOPPED : S_FETCH0;
      S_HALTED:  state_nx = S_HALTED;
      default:   state_nx = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= S_RESET;
      f1_first <= 1'b0;
    end else begin
      state    <= state_nx;
      f1_first <= (state == S_FETCH0);
    end
  end

  always_comb begin
    PC_out          = 1'b0;
    PC_in           = 1'b0;
    IncPC           = 1'b0;
    MAR_in          = 1'b0;
    Read            = 1'b0;
    MDR_in          = 1'b0;
    MDR_out         = 1'b0;
    IR_in           = 1'b0;
    Y_in            = 1'b0;
    Z_in            = 1'b0;
    Zlow_out        = 1'b0;
    Zhigh_out       = 1'b0;
    HI_in           = 1'b0;
    LO_in           = 1'b0;
    Rin             = '0;
    Rout            = '0;
    alu_instruction = 5'd0;
    illegal         = 1'b0;
    run             = ~(state == S_RESET || state == S_STOPPED || state == S_HALTED);
    case (state)
      S_FETCH0: begin
        PC_out = 1'b1;
        MAR_in = 1'b1;
        IncPC  = 1'b1;
        Z_in   = 1'b1;
      end
      S_FETCH1: begin
        // Read/MDR_in hold through a stall; PC loads once so it advances by one
        Zlow_out = 1'b1;
        PC_in    = f1_first;
        Read     = 1'b1;
        MDR_in   = 1'b1;
      end
      S_FETCH2: begin
        MDR_out = 1'b1;
        IR_in   = 1'b1;
      end
      S_EX1: begin
        if (is_bin | is_wide) begin
          Rout    = sel(rb, rb_bad);
          Y_in    = 1'b1;
          illegal = rb_bad;
        end else if (is_un) begin
          Rout            = sel(rb, rb_bad);
          alu_instruction = op;
          Z_in            = 1'b1;
          illegal         = rb_bad;
        end else begin
          illegal = is_ill;
        end
      end
      S_EX2: begin
        if (is_un) begin
          Zlow_out = 1'b1;
          Rin      = sel(ra, ra_bad);
          illegal  = ra_bad;
        end else begin
          Rout            = sel(rc, rc_bad);
          alu_instruction = op;
          Z_in            = 1'b1;
          illegal         = rc_bad;
        end
      end
      S_EX3: begin
        Zlow_out = 1'b1;
        if (is_wide) begin
          LO_in = 1'b1;
        end else begin
          Rin     = sel(ra, ra_bad);
          illegal = ra_bad;
        end
      end
      S_EX4: begin
        Zhigh_out = 1'b1;
        HI_in     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr, mem_ready, stop;
  logic [31:0] ir;
  logic        PC_out, PC_in, IncPC, MAR_in, Read, MDR_in, MDR_out, IR_in;
  logic        Y_in, Z_in, Zlow_out, Zhigh_out, HI_in, LO_in;
  logic [15:0] Rin, Rout;
  logic [4:0]  alu_instruction;
  logic        run, illegal;

  always #5 clk = ~clk;

  control_sequencer #(.NREGS(16)) dut (
    .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready), .stop(stop),
    .PC_out(PC_out), .PC_in(PC_in), .IncPC(IncPC), .MAR_in(MAR_in),
    .Read(Read), .MDR_in(MDR_in), .MDR_out(MDR_out), .IR_in(IR_in),
    .Y_in(Y_in), .Z_in(Z_in), .Zlow_out(Zlow_out), .Zhigh_out(Zhigh_out),
    .HI_in(HI_in), .LO_in(LO_in), .Rin(Rin), .Rout(Rout),
    .alu_instruction(alu_instruction), .run(run), .illegal(illegal)
  );

  typedef struct packed {
    logic pc_out, pc_in, inc_pc, mar_in, rd, mdr_in, mdr_out, ir_in;
    logic y_in, z_in, zlow, zhigh, hi_in, lo_in;
    logic [15:0] rin, rout;
    logic [4:0]  alu;
    logic run, illegal;
  } ctl_t;

  ctl_t act;
  assign act = {PC_out, PC_in, IncPC, MAR_in, Read, MDR_in, MDR_out, IR_in,
                Y_in, Z_in, Zlow_out, Zhigh_out, HI_in, LO_in, Rin, Rout,
                alu_instruction, run, illegal};

  int errors = 0;
  int checks = 0;
  ctl_t exp_q[$];

  task automatic chk_ctl(input string nm, input int k, input ctl_t a, input ctl_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s k=%0d got=%h exp=%h", nm, k, a, e);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, a, e);
    end
  endtask

  // 0 binary, 1 wide, 2 unary, 3 nop, 4 halt, 5 illegal
  function automatic int op_class(input logic [4:0] op);
    if (op inside {[5'd3:5'd11]})     return 0;
    if (op inside {5'd15, 5'd16})     return 1;
    if (op inside {5'd17, 5'd18})     return 2;
    if (op == 5'd26)                  return 3;
    if (op == 5'd27)                  return 4;
    return 5;
  endfunction

  function automatic ctl_t live();
    ctl_t c = '0;
    c.run = 1'b1;
    return c;
  endfunction

  // Expected per-cycle strobe list for one instruction, from FETCH0 to its last state
  task automatic build_exp(input logic [31:0] i, input int stall);
    ctl_t c;
    logic [4:0]  op = i[31:27];
    logic [15:0] ra = 16'(1) << i[26:23];
    logic [15:0] rb = 16'(1) << i[22:19];
    logic [15:0] rc = 16'(1) << i[18:15];
    int cl = op_class(op);
    exp_q.delete();
    c = live(); c.pc_out = 1; c.mar_in = 1; c.inc_pc = 1; c.z_in = 1; exp_q.push_back(c);
    for (int s = 0; s <= stall; s++) begin
      c = live(); c.zlow = 1; c.rd = 1; c.mdr_in = 1; c.pc_in = (s == 0); exp_q.push_back(c);
    end
    c = live(); c.mdr_out = 1; c.ir_in = 1; exp_q.push_back(c);
    if (cl <= 1) begin
      c = live(); c.rout = rb; c.y_in = 1; exp_q.push_back(c);
      c = live(); c.rout = rc; c.alu = op; c.z_in = 1; exp_q.push_back(c);
      c = live(); c.zlow = 1;
      if (cl == 0) c.rin = ra; else c.lo_in = 1;
      exp_q.push_back(c);
      if (cl == 1) begin
        c = live(); c.zhigh = 1; c.hi_in = 1; exp_q.push_back(c);
      end
    end else if (cl == 2) begin
      c = live(); c.rout = rb; c.alu = op; c.z_in = 1; exp_q.push_back(c);
      c = live(); c.zlow = 1; c.rin = ra; exp_q.push_back(c);
    end else begin
      c = live(); c.illegal = (cl == 5); exp_q.push_back(c);
    end
  endtask

  // Starts at a negedge with the DUT in FETCH0; returns at the negedge of the
  // next FETCH0 (or first idle cycle). abort_at >= 0 asserts clr in that cycle.
  task automatic run_instr(input logic [31:0] i, input int stall, input logic stp,
                           input int abort_at, output int cyc, output logic [15:0] rin_or,
                           output int ill_n, output int pcin_n);
    int k;
    build_exp(i, stall);
    ir = i; stop = stp;
    rin_or = '0; ill_n = 0; pcin_n = 0;
    for (k = 0; k < 30; k++) begin
      if (k > 0 && (act.pc_out || !act.run)) break;
      if (k < exp_q.size()) chk_ctl("cycle", k, act, exp_q[k]);
      else chk_int("overrun", k, exp_q.size() - 1);
      rin_or |= act.rin;
      ill_n  += int'(act.illegal);
      pcin_n += int'(act.pc_in);
      mem_ready = (k > stall);
      if (k == abort_at) begin
        clr = 1'b1;
        #1 chk_ctl("clr_async", k, act, '0);
        cyc = k;
        return;
      end
      @(posedge clk); @(negedge clk);
    end
    if (k == 30) chk_int("timeout", k, exp_q.size());
    cyc = k;
  endtask

  typedef struct {
    logic [31:0] i;
    int          stall;
    int          cyc;
    logic [15:0] rin;
    int          ill;
  } vec_t;

  vec_t tbl[10];
  int cyc, ill_n, pcin_n, n_exp;
  logic [15:0] rin_or;
  logic [4:0] legal_ops[15];
  logic [4:0] rop;
  logic [31:0] ri;
  int rs;

  initial begin
    tbl[0] = '{32'h90080000, 0, 5, 16'h0001, 0}; // not R0,R1
    tbl[1] = '{32'h19008000, 0, 6, 16'h0004, 0}; // add R2,R0,R1
    tbl[2] = '{32'h781A0000, 0, 7, 16'h0000, 0}; // mul R3,R4
    tbl[3] = '{32'h802B0000, 0, 7, 16'h0000, 0}; // div R5,R6
    tbl[4] = '{32'h19008000, 3, 9, 16'h0004, 0}; // add, 3-cycle stall
    tbl[5] = '{32'hF8000000, 0, 4, 16'h0000, 1}; // opcode 11111
    tbl[6] = '{32'hD0000000, 0, 4, 16'h0000, 0}; // nop
    tbl[7] = '{32'h8FF00000, 1, 6, 16'h8000, 0}; // neg R15,R14, stall 1
    tbl[8] = '{32'h5BC48000, 2, 8, 16'h0080, 0}; // rol R7,R8,R9, stall 2
    tbl[9] = '{32'h00000000, 0, 4, 16'h0000, 1}; // opcode 00000
    legal_ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                  5'd15, 5'd16, 5'd17, 5'd18, 5'd26, 5'd3};

    clr = 1'b1; stop = 1'b0; mem_ready = 1'b1; ir = '0;
    @(negedge clk); @(negedge clk);
    chk_ctl("reset", 0, act, '0);
    clr = 1'b0;
    #1 chk_ctl("reset_release", 0, act, '0);
    @(posedge clk); @(negedge clk);

    // Table vectors
    for (int t = 0; t < 10; t++) begin
      run_instr(tbl[t].i, tbl[t].stall, 1'b0, -1, cyc, rin_or, ill_n, pcin_n);
      chk_int("tbl_len", cyc, tbl[t].cyc);
      chk_int("tbl_rin", int'(rin_or), int'(tbl[t].rin));
      chk_int("tbl_ill", ill_n, tbl[t].ill);
      chk_int("tbl_pcin", pcin_n, 1);
    end

    // stop during add: completes, then pauses until stop drops
    run_instr(32'h19008000, 0, 1'b1, -1, cyc, rin_or, ill_n, pcin_n);
    chk_int("stop_len", cyc, 6);
    chk_ctl("stopped", 0, act, '0);
    @(posedge clk); @(negedge clk);
    chk_ctl("stopped_hold", 1, act, '0);
    stop = 1'b0;
    @(posedge clk); @(negedge clk);
    run_instr(32'h90080000, 0, 1'b0, -1, cyc, rin_or, ill_n, pcin_n);
    chk_int("resume_len", cyc, 5);

    // clr in EX2 of add (index 4 with no stall)
    run_instr(32'h19008000, 0, 1'b0, 4, cyc, rin_or, ill_n, pcin_n);
    @(posedge clk); @(negedge clk);
    chk_ctl("clr_held", 0, act, '0);
    clr = 1'b0;
    #1 chk_ctl("clr_release", 0, act, '0);
    @(posedge clk); @(negedge clk);
    run_instr(32'h781A0000, 0, 1'b0, -1, cyc, rin_or, ill_n, pcin_n);
    chk_int("after_clr_len", cyc, 7);

    // Randomized instructions against the sequence model
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 4) == 0) begin
        rop = 5'($urandom_range(0, 31));
        if (rop == 5'd27) rop = 5'd31;
      end else begin
        rop = legal_ops[$urandom_range(0, 14)];
      end
      ri = {rop, 27'($urandom)};
      rs = $urandom_range(0, 3);
      build_exp(ri, rs);
      n_exp = exp_q.size();
      run_instr(ri, rs, 1'b0, -1, cyc, rin_or, ill_n, pcin_n);
      chk_int("rand_len", cyc, n_exp);
    end

    // halt: idles with no strobes until clr
    run_instr(32'hD8000000, 0, 1'b0, -1, cyc, rin_or, ill_n, pcin_n);
    chk_int("halt_len", cyc, 4);
    for (int h = 0; h < 5; h++) begin
      chk_ctl("halted", h, act, '0);
      stop = h[0]; mem_ready = ~h[0];
      @(posedge clk); @(negedge clk);
    end
    stop = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk); @(negedge clk);
    run_instr(32'hD0000000, 0, 1'b0, -1, cyc, rin_or, ill_n, pcin_n);
    chk_int("post_halt_len", cyc, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
